score_lives_controller: RTL
===========================

// Module: score_lives_controller
// PURPOSE
//  Consumes the per-pixel collision events from the game controller: gold eaten, player died, alien killed.
//  Turns them into at most one event of each kind per frame.
//  Keeps the BCD score, the lives counter and the play/dying/respawn/game-over sequence.
//  Drives the score/lives display, the player freeze and the respawn pulse.
// PARAMETERS
//  INIT_LIVES    3      lives loaded at reset/restart (0..MAX_LIVES)
//  MAX_LIVES     7      lives ceiling; width 3 bits
//  GOLD_POINTS   500    points per gold-eaten frame (BCD-encodable, <10000)
//  ALIEN_POINTS  250    points per alien-killed frame
//  DEATH_FRAMES  60     frames the player stays frozen after a death (1..255)
//  BONUS_EVERY   20000  extra life each time the score crosses a multiple of this; 0 disables it
// PORTS
//  clk               in   1     system clock
//  resetN            in   1     asynchronous, active-low reset
//  startOfFrame      in   1     one-clk pulse at the start of each frame
//  player_eat_gold_1 in   1     pixel-level; player overlaps a collectible gold bag
//  player_died       in   1     pixel-level; player hit by an alien or a falling bag
//  alien_died_a      in   1     pixel-level; alien hit by a shot or a falling bag
//  restart           in   1     one-clk pulse (debounced key); acted on only in GAME_OVER
//  score_bcd         out  20    5 BCD digits, [19:16]=ten-thousands; saturates at 99999
//  lives             out  3     remaining spare lives
//  player_freeze     out  1     high in DYING and GAME_OVER
//  respawn           out  1     one-clk pulse; player/alien movers re-home on it
//  game_over         out  1     high in GAME_OVER
// BEHAVIOUR
//  Reset (async, resetN=0): score=0, lives=INIT_LIVES, state=PLAY, freeze/respawn/game_over=0.
//   Frame counter and all sticky flags are cleared.
//  Event capture: three sticky flags (gold_f, died_f, kill_f), set on any clk the input is high.
//  On a startOfFrame clk the flags are snapshotted and cleared. An input high on that same clk
//   sets the flag again, so the event counts in the next frame.
//  Consequence: each kind of event counts at most once per frame, however many pixels overlap.
//  Updates are taken on the startOfFrame clk; outputs are registered and visible one clk later.
//  FSM states (enum in package): PLAY, DYING, RESPAWN, GAME_OVER.
//   PLAY: on a snapshot, score += GOLD_POINTS if gold_f, then += ALIEN_POINTS if kill_f.
//    Both additions happen in one update.
//    If died_f: load frame counter = DEATH_FRAMES and go to DYING.
//    Lives decrement there only if lives>0; the score events of that frame are still awarded.
//   DYING: freeze=1; all snapshots are ignored (no score, no second death).
//    The counter decrements each startOfFrame; at 0 go to RESPAWN if the entering death had lives>0.
//    Otherwise go to GAME_OVER.
//   RESPAWN: respawn=1 for exactly one clk, then PLAY on the next clk; the flags are cleared.
//   GAME_OVER: freeze=1, game_over=1; events are ignored.
//    restart loads score=0, lives=INIT_LIVES and goes to PLAY with respawn pulsed.
//    restart in any other state is ignored.
//  Score arithmetic: 5-digit BCD add with a decimal carry per digit.
//   A carry out of digit 4 forces 99999 (saturate, no wrap).
//  Bonus life: when BONUS_EVERY!=0 and floor(score/BONUS_EVERY) increases in an update, lives+1.
//   Lives saturate at MAX_LIVES. Do this as a BCD compare on the top two digits; no binary divide.
//  Lives never underflow below 0; the bonus in the same update as a death applies first.
// STRUCTURE
//  game_pkg: state enum t_life_state, typedef bcd_t (logic[3:0]), NUM_DIGITS=5.
//   Also holds the point/bonus constants shared with the display block.
//  Sub-module bcd_add5: combinational 5-digit BCD adder with saturation.
//   It is instantiated once; the operand is GOLD_POINTS, ALIEN_POINTS or their sum,
//   picked by a mux from the flags.
//  Everything else (flags, FSM, counters) stays in this module.
// TESTING
//  1 gold overlap held for 40 clks in one frame -> score 0x00500 after the next startOfFrame, not 20000.
//  2 gold and alien kill in the same frame -> score +750 once; event on the startOfFrame clk counts next frame.
//  3 death with lives=3 -> lives=2, freeze for 60 frames, respawn 1 clk, back to PLAY; deaths while DYING ignored.
//  4 death with lives=0 -> freeze, game_over=1 after 60 frames; restart -> score 0, lives 3, respawn pulse.
//  5 40 gold frames (score crosses 20000) -> lives +1, capped at 7.
//   200 gold frames -> score holds 0x99999.
//  6 resetN dropped mid-DYING -> all outputs at reset values immediately; freeze=0, no respawn pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types and constants for the score/lives logic and the display block.
// Scores are kept as NUM_DIGITS packed BCD digits, most significant digit in the top nibble.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY,
        DYING,
        RESPAWN,
        GAME_OVER
    } t_life_state;

    typedef logic [3:0] bcd_t;

    localparam int unsigned NUM_DIGITS      = 5;
    localparam int unsigned SCORE_W         = 4 * NUM_DIGITS;
    localparam int unsigned GOLD_POINTS_DEF = 500;
    localparam int unsigned ALIEN_POINTS_DEF = 250;
    localparam int unsigned BONUS_EVERY_DEF = 20000;

    // Elaboration-time helper: binary constant to packed BCD.
    function automatic logic [SCORE_W-1:0] to_bcd(input int unsigned value);
        logic [SCORE_W-1:0] r;
        int unsigned        v;
        r = '0;
        v = value;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = bcd_t'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_lives_controller_if.sv
// Event/display bundle between the game controller (master) and score_lives_controller (slave).
interface score_lives_controller_if;
    import game_pkg::*;

    logic               startOfFrame;
    logic               player_eat_gold_1;
    logic               player_died;
    logic               alien_died_a;
    logic               restart;
    logic [SCORE_W-1:0] score_bcd;
    logic [2:0]         lives;
    logic               player_freeze;
    logic               respawn;
    logic               game_over;

    modport master (
        output startOfFrame, player_eat_gold_1, player_died, alien_died_a, restart,
        input  score_bcd, lives, player_freeze, respawn, game_over
    );

    modport slave (
        input  startOfFrame, player_eat_gold_1, player_died, alien_died_a, restart,
        output score_bcd, lives, player_freeze, respawn, game_over
    );

endinterface

// File: rtl/score_lives_controller_bcd_add5.sv
// Combinational 5-digit BCD adder; a carry out of the top digit saturates the result at all nines.
module bcd_add5
    import game_pkg::*;
(
    input  logic [SCORE_W-1:0] a,
    input  logic [SCORE_W-1:0] b,
    output logic [SCORE_W-1:0] sum
);

    logic [SCORE_W-1:0] raw;
    logic [4:0]         dsum;
    logic               c;

    always_comb begin
        raw  = '0;
        dsum = '0;
        c    = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            dsum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (dsum > 5'd9) begin
                raw[4*i +: 4] = 4'(dsum - 5'd10);
                c             = 1'b1;
            end else begin
                raw[4*i +: 4] = dsum[3:0];
                c             = 1'b0;
            end
        end
        sum = c ? {NUM_DIGITS{4'h9}} : raw;
    end

endmodule

// File: rtl/score_lives_controller.sv
// Folds pixel-level collision events into one event per kind per frame, and runs the BCD score,
// lives counter and play/dying/respawn/game-over sequence that drives freeze and respawn.
module score_lives_controller
    import game_pkg::*;
#(
    parameter int unsigned INIT_LIVES   = 3,
    parameter int unsigned MAX_LIVES    = 7,
    parameter int unsigned GOLD_POINTS  = GOLD_POINTS_DEF,
    parameter int unsigned ALIEN_POINTS = ALIEN_POINTS_DEF,
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned BONUS_EVERY  = BONUS_EVERY_DEF
) (
    input logic                     clk,
    input logic                     resetN,
    score_lives_controller_if.slave bus
);

    localparam logic [SCORE_W-1:0] GOLD_BCD  = to_bcd(GOLD_POINTS);
    localparam logic [SCORE_W-1:0] ALIEN_BCD = to_bcd(ALIEN_POINTS);
    localparam logic [SCORE_W-1:0] BOTH_BCD  = to_bcd(GOLD_POINTS + ALIEN_POINTS);
    localparam logic [2:0]         INIT_L    = 3'(INIT_LIVES);
    localparam logic [2:0]         MAX_L     = 3'(MAX_LIVES);
    localparam int unsigned N_THRESH =
        (BONUS_EVERY != 0) ? 99999 / ((BONUS_EVERY == 0) ? 1 : BONUS_EVERY) : 0;

    t_life_state        state;
    logic               gold_f, died_f, kill_f;
    logic [7:0]         frame_cnt;
    logic               death_had_life;
    logic [SCORE_W-1:0] score, operand, score_sum;
    logic [2:0]         lives, lives_bonus, lives_play;
    logic               freeze_r, respawn_r, game_over_r;
    logic [N_THRESH:0]  crossed;
    logic               bonus_hit;

    bcd_add5 u_add (
        .a   (score),
        .b   (operand),
        .sum (score_sum)
    );

    always_comb begin
        operand = '0;
        unique case ({gold_f, kill_f})
            2'b11:   operand = BOTH_BCD;
            2'b10:   operand = GOLD_BCD;
            2'b01:   operand = ALIEN_BCD;
            default: operand = '0;
        endcase
    end

    // Thresholds are multiples of 1000, so comparing the top two BCD digits is exact.
    assign crossed[0] = 1'b0;
    for (genvar k = 1; k <= N_THRESH; k++) begin : g_bonus
        localparam logic [SCORE_W-1:0] THRESH = to_bcd(k * BONUS_EVERY);
        assign crossed[k] = (score[SCORE_W-1 -: 8] < THRESH[SCORE_W-1 -: 8]) &&
                            (score_sum[SCORE_W-1 -: 8] >= THRESH[SCORE_W-1 -: 8]);
    end
    assign bonus_hit = |crossed;

    always_comb begin
        lives_bonus = (bonus_hit && (lives < MAX_L)) ? lives + 3'd1 : lives;
        lives_play  = lives_bonus;
        if (died_f) begin
            lives_play = (lives_bonus != '0) ? lives_bonus - 3'd1 : '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= PLAY;
            score          <= '0;
            lives          <= INIT_L;
            gold_f         <= 1'b0;
            died_f         <= 1'b0;
            kill_f         <= 1'b0;
            frame_cnt      <= '0;
            death_had_life <= 1'b0;
            freeze_r       <= 1'b0;
            respawn_r      <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            respawn_r <= 1'b0;

            // The snapshot below reads the old flags; an input on the frame clk re-arms them.
            if (state == RESPAWN) begin
                {gold_f, died_f, kill_f} <= '0;
            end else if (bus.startOfFrame) begin
                gold_f <= bus.player_eat_gold_1;
                died_f <= bus.player_died;
                kill_f <= bus.alien_died_a;
            end else begin
                gold_f <= gold_f | bus.player_eat_gold_1;
                died_f <= died_f | bus.player_died;
                kill_f <= kill_f | bus.alien_died_a;
            end

            unique case (state)
                PLAY: begin
                    if (bus.startOfFrame) begin
                        score <= score_sum;
                        lives <= lives_play;
                        if (died_f) begin
                            frame_cnt      <= 8'(DEATH_FRAMES);
                            death_had_life <= (lives_bonus != '0);
                            state          <= DYING;
                            freeze_r       <= 1'b1;
                        end
                    end
                end
                DYING: begin
                    if (bus.startOfFrame) begin
                        if (frame_cnt == 8'd1) begin
                            frame_cnt <= '0;
                            if (death_had_life) begin
                                state     <= RESPAWN;
                                respawn_r <= 1'b1;
                                freeze_r  <= 1'b0;
                            end else begin
                                state       <= GAME_OVER;
                                game_over_r <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt - 8'd1;
                        end
                    end
                end
                RESPAWN: begin
                    state <= PLAY;
                end
                GAME_OVER: begin
                    if (bus.restart) begin
                        score       <= '0;
                        lives       <= INIT_L;
                        state       <= RESPAWN;
                        respawn_r   <= 1'b1;
                        freeze_r    <= 1'b0;
                        game_over_r <= 1'b0;
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

    assign bus.score_bcd     = score;
    assign bus.lives         = lives;
    assign bus.player_freeze = freeze_r;
    assign bus.respawn       = respawn_r;
    assign bus.game_over     = game_over_r;

endmodule
